// File: rtl/ccff_stream_loader.sv
// Streams configuration words MSB first into a ccff scan chain,
// counting shifted bits and folding the chain tail into a parity bit.
module ccff_stream_loader #(
  parameter int CHAIN_LEN = 30,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [WW-1:0]     left_q, left_d;
  logic              acc_q, acc_d;
  logic              head_q, head_d;
  logic              sh_q, sh_d;
  logic              par_q, par_d;
  logic              last_bit;
  logic              hs;

  // left_q counts unshifted bits, including the one now on the head
  always_comb begin
    last_bit  = sh_q && (bit_cnt_q == LAST);
    cfg_ready = (state_q == S_LOAD) && !last_bit &&
                ((left_q == '0) || ((left_q == WW'(1)) && sh_q));
    hs        = cfg_ready && cfg_valid;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    left_d    = left_q;
    acc_d     = acc_q;
    head_d    = head_q;
    sh_d      = 1'b0;
    par_d     = par_q;
    if (abort) begin
      state_d = S_IDLE;
      left_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_LOAD;
            bit_cnt_d = '0;
            word_d    = '0;
            left_d    = '0;
            acc_d     = 1'b0;
          end
        end
        S_LOAD: begin
          if (sh_q) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            acc_d     = acc_q ^ ccff_tail;
            left_d    = left_q - 1'b1;
          end
          if (last_bit) begin
            state_d = S_DONE;
            par_d   = acc_d;
            left_d  = '0;
          end else if (hs) begin
            word_d = cfg_data;
            left_d = WW'(DATA_W);
            head_d = cfg_data[DATA_W-1];
            sh_d   = 1'b1;
          end else if (sh_q && (left_q > WW'(1))) begin
            word_d = word_q << 1;
            head_d = word_q[DATA_W-2];
            sh_d   = 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      word_q    <= '0;
      left_q    <= '0;
      acc_q     <= 1'b0;
      head_q    <= 1'b0;
      sh_q      <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      left_q    <= left_d;
      acc_q     <= acc_d;
      head_q    <= head_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = sh_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign tail_parity   = par_q;

endmodule
